// File: rtl/atmega_clkgen.sv
// Clock generator with a PLL-style lock sequencer and CHANNELS fractional clock-enable dividers.
// Registers: CSR at BASE_ADDR, then one DIV/FRAC pair per channel.
module atmega_clkgen #(
  parameter int BUS_ADDR_DATA_LEN = 16,
  parameter int BASE_ADDR         = 'h29,
  parameter int CHANNELS          = 4,
  parameter int LOCK_CYCLES       = 64
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  output logic                         locked,
  output logic [CHANNELS-1:0]          ce_out,
  output logic [CHANNELS-1:0]          tog_out,
  output logic [1:0]                   dbg_state
);

  localparam int LCW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_LOCKING = 2'd1,
    ST_LOCKED  = 2'd2
  } lock_state_t;

  lock_state_t state, state_next;
  logic [LCW-1:0] lock_cnt, lock_cnt_next;

  logic plle, plle_next;
  logic csr_sel;
  logic [CHANNELS-1:0] div_sel, frac_sel;
  logic [7:0] div_q  [CHANNELS];
  logic [7:0] frac_q [CHANNELS];
  logic [7:0] rd_data;

  logic [7:0] cnt_q [CHANNELS];
  logic [7:0] acc_q [CHANNELS];
  logic [8:0] sum   [CHANNELS];
  logic       run;

  // Address decode
  always_comb begin
    div_sel  = '0;
    frac_sel = '0;
    csr_sel  = (addr == BUS_ADDR_DATA_LEN'(BASE_ADDR));
    for (int i = 0; i < CHANNELS; i++) begin
      div_sel[i]  = (addr == BUS_ADDR_DATA_LEN'(BASE_ADDR + 1 + 2 * i));
      frac_sel[i] = (addr == BUS_ADDR_DATA_LEN'(BASE_ADDR + 2 + 2 * i));
    end
  end

  // The lock FSM reacts to the PLLE value being written, so lock timing counts from the write edge.
  assign plle_next = (wr && csr_sel) ? bus_in[0] : plle;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      plle <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        div_q[i]  <= 8'h00;
        frac_q[i] <= 8'h00;
      end
    end else begin
      plle <= plle_next;
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr && div_sel[i])  div_q[i]  <= bus_in;
        if (wr && frac_sel[i]) frac_q[i] <= bus_in;
      end
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if (csr_sel) rd_data = {6'b0, (state == ST_LOCKED), plle};
    for (int i = 0; i < CHANNELS; i++) begin
      if (div_sel[i])  rd_data = div_q[i];
      if (frac_sel[i]) rd_data = frac_q[i];
    end
  end

  assign bus_out = (rd && !rst) ? rd_data : 8'h00;

  // Lock sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_OFF;
      lock_cnt <= '0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    lock_cnt_next = lock_cnt;
    if (!plle_next) begin
      state_next    = ST_OFF;
      lock_cnt_next = '0;
    end else begin
      case (state)
        ST_OFF: begin
          state_next    = ST_LOCKING;
          lock_cnt_next = LCW'(LOCK_CYCLES - 1);
        end
        ST_LOCKING: begin
          if (lock_cnt == '0) state_next = ST_LOCKED;
          else                lock_cnt_next = lock_cnt - LCW'(1);
        end
        ST_LOCKED: state_next = ST_LOCKED;
        default: begin
          state_next    = ST_OFF;
          lock_cnt_next = '0;
        end
      endcase
    end
  end

  assign locked    = (state == ST_LOCKED);
  assign dbg_state = state;
  assign run       = (state == ST_LOCKED) && plle_next;

  // Fractional dividers: the accumulator carry stretches a period by one cycle.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i] = {1'b0, acc_q[i]} + {1'b0, frac_q[i]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_out  <= '0;
      tog_out <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= 8'h00;
        acc_q[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (!run || div_q[i] == 8'h00) begin
          cnt_q[i]   <= 8'h00;
          acc_q[i]   <= 8'h00;
          ce_out[i]  <= 1'b0;
          tog_out[i] <= 1'b0;
        end else if (cnt_q[i] == 8'h00) begin
          ce_out[i]  <= 1'b1;
          tog_out[i] <= ~tog_out[i];
          acc_q[i]   <= sum[i][7:0];
          cnt_q[i]   <= div_q[i] - 8'd1 + {7'd0, sum[i][8]};
        end else begin
          cnt_q[i]  <= cnt_q[i] - 8'd1;
          ce_out[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_atmega_clkgen.sv
// Bench for atmega_clkgen: an absolute-time pulse schedule model predicts lock and ce/tog
// outputs every cycle; register reads are checked against a shadow register file.
module tb_atmega_clkgen;

  localparam int AW   = 16;
  localparam int BASE = 'h29;
  localparam int CH   = 4;
  localparam int LC   = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr;
  logic          wr;
  logic          rd;
  logic [7:0]    bus_in;
  logic [7:0]    bus_out;
  logic          locked;
  logic [CH-1:0] ce_out;
  logic [CH-1:0] tog_out;
  logic [1:0]    dbg_state;

  always #5 clk = ~clk;

  atmega_clkgen #(
    .BUS_ADDR_DATA_LEN(AW),
    .BASE_ADDR(BASE),
    .CHANNELS(CH),
    .LOCK_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .addr(addr),
    .wr(wr),
    .rd(rd),
    .bus_in(bus_in),
    .bus_out(bus_out),
    .locked(locked),
    .ce_out(ce_out),
    .tog_out(tog_out),
    .dbg_state(dbg_state)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: lock is reached at an absolute edge number; each channel
  // remembers the edge of its next pulse and its fractional phase.
  bit m_plle, m_locked;
  int m_lock_edge;
  int cyc;
  int m_div[CH], m_frac[CH], m_acc[CH], m_next[CH];
  bit m_ce[CH], m_tog[CH];

  function automatic void model_reset();
    m_plle      = 1'b0;
    m_locked    = 1'b0;
    m_lock_edge = -1;
    for (int i = 0; i < CH; i++) begin
      m_div[i]  = 0;
      m_frac[i] = 0;
      m_acc[i]  = 0;
      m_next[i] = -1;
      m_ce[i]   = 1'b0;
      m_tog[i]  = 1'b0;
    end
  endfunction

  task automatic check_outputs(input string tag);
    logic [CH-1:0] e_ce, e_tog;
    for (int i = 0; i < CH; i++) begin
      e_ce[i]  = m_ce[i];
      e_tog[i] = m_tog[i];
    end
    vectors++;
    assert (locked === m_locked) else begin
      miscompares++;
      $error("FAIL %s locked cyc=%0d: got %b want %b", tag, cyc, locked, m_locked);
    end
    vectors++;
    assert (ce_out === e_ce) else begin
      miscompares++;
      $error("FAIL %s ce_out cyc=%0d: got %b want %b", tag, cyc, ce_out, e_ce);
    end
    vectors++;
    assert (tog_out === e_tog) else begin
      miscompares++;
      $error("FAIL %s tog_out cyc=%0d: got %b want %b", tag, cyc, tog_out, e_tog);
    end
  endtask

  // One clock edge with an optional write, followed by an output check.
  task automatic cycle(input bit w, input int a, input int d, input string tag);
    bit plle_new, run;
    int s;
    wr     = w;
    addr   = AW'(a);
    bus_in = 8'(d);
    rd     = 1'b0;
    plle_new = (w && a == BASE) ? d[0] : m_plle;
    run      = m_locked && plle_new;
    for (int i = 0; i < CH; i++) begin
      if (!run || m_div[i] == 0) begin
        m_ce[i] = 1'b0; m_tog[i] = 1'b0; m_acc[i] = 0; m_next[i] = -1;
      end else if (m_next[i] < 0 || m_next[i] == cyc) begin
        s         = m_acc[i] + m_frac[i];
        m_ce[i]   = 1'b1;
        m_tog[i]  = !m_tog[i];
        m_acc[i]  = s % 256;
        m_next[i] = cyc + m_div[i] + ((s >= 256) ? 1 : 0);
      end else begin
        m_ce[i] = 1'b0;
      end
    end
    if (!plle_new) begin
      m_locked    = 1'b0;
      m_lock_edge = -1;
    end else begin
      if (m_lock_edge < 0) m_lock_edge = cyc + LC;
      m_locked = (cyc >= m_lock_edge);
    end
    m_plle = plle_new;
    if (w) begin
      for (int i = 0; i < CH; i++) begin
        if (a == BASE + 1 + 2 * i) m_div[i]  = d & 255;
        if (a == BASE + 2 + 2 * i) m_frac[i] = d & 255;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    wr = 1'b0;
    check_outputs(tag);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 0, 0, "idle");
  endtask

  task automatic read_chk(input int a, input string tag);
    logic [7:0] exp_v;
    exp_v = 8'h00;
    if (!rst) begin
      if (a == BASE) exp_v = {6'b0, m_locked, m_plle};
      for (int i = 0; i < CH; i++) begin
        if (a == BASE + 1 + 2 * i) exp_v = 8'(m_div[i]);
        if (a == BASE + 2 + 2 * i) exp_v = 8'(m_frac[i]);
      end
    end
    addr = AW'(a);
    rd   = 1'b1;
    #1;
    vectors++;
    assert (bus_out === exp_v) else begin
      miscompares++;
      $error("FAIL %s read addr=%0h: got %h want %h", tag, a, bus_out, exp_v);
    end
    rd = 1'b0;
  endtask

  int c1_dut, c1_mod, ch, idx, v;

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; bus_in = 8'h00;
    cyc = 0;
    model_reset();
    #1;
    check_outputs("reset");
    read_chk(BASE, "reset_csr");
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    read_chk(BASE, "csr_after_reset");
    read_chk(BASE + 1, "div0_after_reset");

    // Channel setup: 0 = /4, 1 = /3.5, 2 = /5, 3 = random
    cycle(1'b1, BASE + 1, 4, "wr_div0");
    cycle(1'b1, BASE + 2, 0, "wr_frac0");
    cycle(1'b1, BASE + 3, 3, "wr_div1");
    cycle(1'b1, BASE + 4, 128, "wr_frac1");
    cycle(1'b1, BASE + 5, 5, "wr_div2");
    cycle(1'b1, BASE + 7, $urandom_range(1, 6), "wr_div3");
    cycle(1'b1, BASE + 8, $urandom_range(0, 255), "wr_frac3");
    for (int i = 1; i <= 2 * CH; i++) read_chk(BASE + i, "reg_readback");

    // Lock sequence and read-only PLOCK
    cycle(1'b1, BASE, 1, "wr_csr_en");
    read_chk(BASE, "csr_locking");
    idle(LC + 8);
    read_chk(BASE, "csr_locked");
    cycle(1'b1, BASE, 8'hFF, "wr_csr_ff");
    read_chk(BASE, "csr_ff");

    // Fractional channel over 512 cycles
    c1_dut = 0; c1_mod = 0;
    for (int k = 0; k < 512; k++) begin
      cycle(1'b0, 0, 0, "frac_run");
      if (ce_out[1]) c1_dut++;
      if (m_ce[1])   c1_mod++;
    end
    vectors++;
    assert (c1_dut === c1_mod) else begin
      miscompares++;
      $error("FAIL ch1_pulses: got %0d want %0d", c1_dut, c1_mod);
    end
    vectors++;
    assert (c1_dut >= 146 && c1_dut <= 147) else begin
      miscompares++;
      $error("FAIL ch1_pulse_range: got %0d want 146..147", c1_dut);
    end

    // DIV2 5 -> 2 mid-count, then 0, then restart
    idle($urandom_range(1, 4));
    cycle(1'b1, BASE + 5, 2, "div2_to_2");
    idle(20);
    cycle(1'b1, BASE + 5, 0, "div2_to_0");
    idle(8);
    cycle(1'b1, BASE + 5, 3, "div2_restart");
    idle(12);

    // Random register traffic with occasional CSR toggles
    for (int k = 0; k < 60; k++) begin
      ch  = $urandom_range(0, CH - 1);
      idx = $urandom_range(0, 19);
      if (idx == 0) begin
        cycle(1'b1, BASE, $urandom_range(0, 255), "rand_csr");
      end else begin
        v = (idx < 10) ? $urandom_range(0, 7) : $urandom_range(0, 255);
        cycle(1'b1, BASE + 1 + 2 * ch + ((idx < 10) ? 0 : 1), v, "rand_wr");
      end
      idle($urandom_range(0, 6));
      if (k % 10 == 0) read_chk(BASE + 1 + 2 * ch, "rand_read");
    end

    // Disable while running, then relock
    cycle(1'b1, BASE, 1, "reen");
    cycle(1'b1, BASE + 1, 4, "div0_again");
    idle(LC + 10);
    cycle(1'b1, BASE, 0, "disable");
    read_chk(BASE, "csr_disabled");
    idle(3);
    cycle(1'b1, BASE, 1, "relock");
    idle(LC + 10);
    read_chk(BASE, "csr_relocked");

    // Asynchronous reset while locked
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    read_chk(BASE + 1, "div0_in_rst");
    @(posedge clk);
    #2;
    rst = 1'b0;
    read_chk(BASE, "csr_after_rst");
    read_chk(BASE + 1, "div0_after_rst");
    read_chk(BASE + 1 + 2 * CH, "unmapped_hi");
    read_chk(0, "unmapped_zero");
    idle(LC + 4);
    read_chk(BASE, "csr_stays_off");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
